// File: rtl/nr_div_stream.sv
// Streaming non-restoring divider: loads DW/VW-bit operands in BLK-bit beats, iterates one quotient bit per cycle, streams results.
// Optional macro NR_DIV_REM_OUT_EN enables the remainder correction and the remainder_out stream.
module nr_div_stream #(
  parameter int DW  = 4096,
  parameter int VW  = 2048,
  parameter int BLK = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_in,
  input  logic           data_vld_in,
  input  logic [BLK-1:0] dividend_in,
  input  logic [BLK-1:0] divisor_in,
  input  logic           out_ready,
  output logic           busy,
  output logic [BLK-1:0] quotient_out,
  output logic [BLK-1:0] remainder_out,
  output logic           data_vld_out,
  output logic           done_out,
  output logic           div_zero
);
  localparam int NB  = DW / BLK;
  localparam int VB  = VW / BLK;
  localparam int BCW = $clog2(NB) + 1;
  localparam int ICW = $clog2(DW) + 1;
  localparam logic [BCW-1:0] NB_LAST = BCW'(NB - 1);
  localparam logic [BCW-1:0] VB_C    = BCW'(VB);
  localparam logic [ICW-1:0] DW_LAST = ICW'(DW - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, OUT, DONE} state_t;

  state_t         state, state_nx;
  logic [BCW-1:0] bcnt;
  logic [ICW-1:0] icnt;
  logic [DW-1:0]  q, q_ld;
  logic [VW-1:0]  d, d_ld;
  logic [VW:0]    p;
  logic           dz;
  logic [VW+1:0]  two_p, p_nx;
  logic           load_last, out_last;

  // Operand registers with the current beat merged in, so the last beat is visible to the zero test.
  always_comb begin
    q_ld = q;
    d_ld = d;
    q_ld[bcnt*BLK +: BLK] = dividend_in;
    if (bcnt < VB_C) d_ld[bcnt*BLK +: BLK] = divisor_in;
  end

  // {p,b} read as a signed VW+2-bit value is 2P+b; the next P always fits back into VW+1 bits.
  always_comb begin
    two_p = {p, q[DW-1]};
    p_nx  = p[VW] ? (two_p + {2'b00, d}) : (two_p - {2'b00, d});
  end

  assign load_last = (state == LOAD) && data_vld_in && (bcnt == NB_LAST);
  assign out_last  = (state == OUT) && out_ready && (bcnt == NB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_in) state_nx = LOAD;
      LOAD: if (load_last) state_nx = (d_ld == '0) ? FIX : ITER;
      ITER: if (icnt == DW_LAST) state_nx = FIX;
      FIX:  state_nx = OUT;
      OUT:  if (out_last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
      icnt <= '0;
      q    <= '0;
      d    <= '0;
      p    <= '0;
      dz   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          dz   <= 1'b0;
          bcnt <= '0;
          icnt <= '0;
          p    <= '0;
        end
        LOAD: if (data_vld_in) begin
          q    <= q_ld;
          d    <= d_ld;
          bcnt <= load_last ? '0 : bcnt + 1'b1;
          if (load_last && d_ld == '0) begin
            dz <= 1'b1;
            q  <= '1;
            p  <= {1'b0, q_ld[VW-1:0]};
          end
        end
        ITER: begin
          p    <= p_nx[VW:0];
          q    <= {q[DW-2:0], ~p_nx[VW]};
          icnt <= icnt + 1'b1;
        end
`ifdef NR_DIV_REM_OUT_EN
        FIX: if (p[VW]) p <= p + {1'b0, d};
`endif
        OUT: if (out_ready) bcnt <= out_last ? '0 : bcnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign data_vld_out = (state == OUT);
  assign done_out     = (state == DONE);
  assign div_zero     = dz;
  assign quotient_out = data_vld_out ? q[bcnt*BLK +: BLK] : '0;
`ifdef NR_DIV_REM_OUT_EN
  assign remainder_out = (data_vld_out && bcnt < VB_C) ? p[bcnt*BLK +: BLK] : '0;
`else
  assign remainder_out = '0;
`endif

endmodule

// File: tb/tb_nr_div_stream.sv
// Directed bench for nr_div_stream at DW=64, VW=32, BLK=16 with hand-computed results.
module tb_nr_div_stream;
  localparam int DW = 64, VW = 32, BLK = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_in = 1'b0;
  logic           data_vld_in = 1'b0;
  logic [BLK-1:0] dividend_in = '0;
  logic [BLK-1:0] divisor_in = '0;
  logic           out_ready = 1'b0;
  logic           busy, data_vld_out, done_out, div_zero;
  logic [BLK-1:0] quotient_out, remainder_out;

  int checks = 0;
  int errors = 0;

  nr_div_stream #(.DW(DW), .VW(VW), .BLK(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .data_vld_in(data_vld_in),
    .dividend_in(dividend_in), .divisor_in(divisor_in), .out_ready(out_ready),
    .busy(busy), .quotient_out(quotient_out), .remainder_out(remainder_out),
    .data_vld_out(data_vld_out), .done_out(done_out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rexp(input logic [63:0] r);
`ifdef NR_DIV_REM_OUT_EN
    return r;
`else
    return 64'(r & 64'h0);
`endif
  endfunction

  // Garbage on the data inputs during the start cycle must be ignored.
  task automatic start_op;
    start_in = 1'b1;
    data_vld_in = 1'b1;
    dividend_in = 16'hBEEF;
    divisor_in = 16'hBEEF;
    tick;
    start_in = 1'b0;
    data_vld_in = 1'b0;
  endtask

  task automatic load(input logic [63:0] dv, input logic [31:0] ds, input bit gap, input bit mid_start);
    for (int i = 0; i < 4; i++) begin
      if (gap && i == 2) begin
        data_vld_in = 1'b0;
        dividend_in = 16'hFFFF;
        divisor_in = 16'hFFFF;
        tick;
      end
      data_vld_in = 1'b1;
      dividend_in = dv[i*16 +: 16];
      divisor_in = (i < 2) ? ds[i*16 +: 16] : 16'hA5A5;
      start_in = mid_start && (i == 1);
      tick;
    end
    data_vld_in = 1'b0;
    start_in = 1'b0;
  endtask

  task automatic run(input string tag, input logic [63:0] exp_q, input logic [63:0] exp_r,
                     input int exp_lat, input bit stall);
    int lat = 0;
    int beats = 0;
    logic [1:0] k = 2'd0;
    logic [3:0] pat = 4'b1001;
    logic [63:0] qa = '0;
    logic [63:0] ra = '0;
    logic [15:0] hq = '0;
    logic [15:0] hr = '0;
    bit held = 1'b0;
    while (!data_vld_out && lat < 200) begin
      tick;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    for (int c = 0; c < 40 && beats < 4; c++) begin
      out_ready = stall ? pat[k] : 1'b1;
      k++;
      if (held) begin
        check({tag, "_hold_q"}, 64'(quotient_out), 64'(hq));
        check({tag, "_hold_r"}, 64'(remainder_out), 64'(hr));
      end
      if (out_ready && data_vld_out) begin
        qa[beats*16 +: 16] = quotient_out;
        ra[beats*16 +: 16] = remainder_out;
        beats++;
        held = 1'b0;
      end else begin
        held = data_vld_out;
        hq = quotient_out;
        hr = remainder_out;
      end
      tick;
    end
    out_ready = 1'b0;
    check({tag, "_beats"}, 64'(beats), 64'd4);
    check({tag, "_done"}, 64'(done_out), 64'd1);
    check({tag, "_quot"}, qa, exp_q);
    check({tag, "_rem"}, ra, exp_r);
    tick;
    check({tag, "_done_pulse"}, 64'(done_out), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_q"}, 64'(quotient_out), 64'd0);
    check({tag, "_r"}, 64'(remainder_out), 64'd0);
    check({tag, "_vld"}, 64'(data_vld_out), 64'd0);
    check({tag, "_done"}, 64'(done_out), 64'd0);
    check({tag, "_dz"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    tick;
    tick;
    check_zero_outs("reset");
    rst_n = 1'b1;
    tick;

    start_op;
    load(64'd100, 32'd7, 1'b1, 1'b0);
    run("d100_7", 64'd14, rexp(64'd2), 65, 1'b0);
    check("d100_7_dz", 64'(div_zero), 64'd0);

    start_op;
    load(64'h1234, 32'd0, 1'b0, 1'b0);
    run("divzero", 64'hFFFF_FFFF_FFFF_FFFF, rexp(64'h1234), 1, 1'b0);
    check("divzero_flag", 64'(div_zero), 64'd1);
    tick;
    tick;
    check("divzero_held", 64'(div_zero), 64'd1);

    start_op;
    check("dz_clear_on_start", 64'(div_zero), 64'd0);
    load(64'd5, 32'd9, 1'b0, 1'b0);
    run("d5_9", 64'd0, rexp(64'd5), 65, 1'b0);

    start_op;
    load(64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run("dmax_1", 64'hFFFF_FFFF_FFFF_FFFF, rexp(64'd0), 65, 1'b0);

    start_op;
    load(64'd1000, 32'd13, 1'b0, 1'b0);
    run("stall", 64'd76, rexp(64'd12), 65, 1'b1);

    start_op;
    load(64'd1000, 32'd13, 1'b0, 1'b1);
    run("midstart", 64'd76, rexp(64'd12), 65, 1'b0);

    start_op;
    load(64'd100, 32'd7, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick;
    check("abort_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outs("abort");
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    check("abort_no_restart", 64'(busy), 64'd0);

    start_op;
    load(64'hDEAD_BEEF_1234_5678, 32'h0001_0000, 1'b0, 1'b0);
    run("after_abort", 64'h0000_DEAD_BEEF_1234, rexp(64'h5678), 65, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
